// File: rtl/theremin_iir_sched_pkg.sv
// Shared types for the theremin IIR stage scheduler.
// Holds the FSM state encoding and the in-flight datapath op record.
package theremin_iir_sched_pkg;

    localparam int SCHED_STAGE_BITS = 2;
    localparam int DP_LATENCY_MAX   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } sched_state_t;

    typedef logic [SCHED_STAGE_BITS-1:0] op_stage_t;

    typedef struct packed {
        logic      valid;
        op_stage_t stage;
        logic      ch;
        logic      last;
    } iir_op_t;

endpackage

// File: rtl/theremin_iir_stage_scheduler_pipe.sv
// In-flight op tracker: DEPTH-stage shift register of issued ops.
// Ports: clk, clear (sync), op_in (issued op or empty slot),
//   query_stage/query_ch -> hit (that op still in flight),
//   empty (nothing in flight), tail (op being written back).
module iir_op_pipe
    import theremin_iir_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      clear,
    input  iir_op_t   op_in,
    input  op_stage_t query_stage,
    input  logic      query_ch,
    output logic      hit,
    output logic      empty,
    output iir_op_t   tail
);

    iir_op_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= op_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // An op still anywhere in the pipe (including the tail, which is
    // writing this cycle) has not yet landed in state RAM.
    always_comb begin
        hit   = 1'b0;
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].valid) begin
                empty = 1'b0;
                if (pipe_q[i].stage == query_stage &&
                    pipe_q[i].ch == query_ch) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/theremin_iir_stage_scheduler.sv
// Issue scheduler for the 2-channel cascaded IIR smoothing filter.
// In: CLK, RESETN (sync, active-low), START, MAX_STAGE.
// Out: RD_EN/RD_ADDR/SRC_ADDR/SRC_IS_INPUT (issue), WR_EN/WR_ADDR/
//   WR_LAST (write-back), BUSY, DONE (pulse), OVERRUN (sticky).
module theremin_iir_stage_scheduler
    import theremin_iir_sched_pkg::*;
#(
    parameter int STAGE_BITS = 2,
    parameter int DP_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [STAGE_BITS-1:0] MAX_STAGE,
    output logic                  RD_EN,
    output logic [STAGE_BITS:0]   RD_ADDR,
    output logic [STAGE_BITS:0]   SRC_ADDR,
    output logic                  SRC_IS_INPUT,
    output logic                  WR_EN,
    output logic [STAGE_BITS:0]   WR_ADDR,
    output logic                  WR_LAST,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERRUN
);

    // Pipe depth held to the legal datapath latency range.
    localparam int LAT = (DP_LATENCY > DP_LATENCY_MAX) ? DP_LATENCY_MAX :
                         (DP_LATENCY < 1) ? 1 : DP_LATENCY;

    sched_state_t          state_q, state_d;
    logic [STAGE_BITS-1:0] stage_q, stage_d;
    logic [STAGE_BITS-1:0] m_q, m_d;
    logic [STAGE_BITS-1:0] stage_prev;
    logic                  ch_q, ch_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic                  rd_en;
    logic                  done;
    logic                  hit;
    logic                  hazard;
    logic                  pipe_empty;
    logic                  finishing;
    iir_op_t               op_in;
    iir_op_t               tail;

    assign stage_prev = stage_q - 1'b1;
    assign hazard     = (stage_q != '0) && hit;
    assign finishing  = (state_q == S_DRAIN) && pipe_empty;

    iir_op_pipe #(.DEPTH(LAT)) u_pipe (
        .clk         (CLK),
        .clear       (!RESETN),
        .op_in       (op_in),
        .query_stage (op_stage_t'(stage_prev)),
        .query_ch    (ch_q),
        .hit         (hit),
        .empty       (pipe_empty),
        .tail        (tail)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            ch_q    <= 1'b0;
            m_q     <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            ch_q    <= ch_d;
            m_q     <= m_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        ch_d    = ch_q;
        m_d     = m_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        rd_en   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ISSUE;
                    m_d     = MAX_STAGE;
                    stage_d = '0;
                    ch_d    = 1'b0;
                end
            end
            S_ISSUE: begin
                rd_en = !hazard;
                if (rd_en) begin
                    if (!ch_q) begin
                        ch_d = 1'b1;
                    end else if (stage_q == m_q) begin
                        state_d = S_DRAIN;
                        stage_d = '0;
                        ch_d    = 1'b0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        ch_d    = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    done = 1'b1;
                    // Queued or coincident START chains straight into
                    // the next pass; a START arriving alongside a queued
                    // one becomes the new queued request.
                    if (pend_q || START) begin
                        state_d = S_ISSUE;
                        m_d     = MAX_STAGE;
                        pend_d  = pend_q && START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (START && state_q != S_IDLE && !finishing) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_comb begin
        op_in = '0;
        if (rd_en) begin
            op_in.valid = 1'b1;
            op_in.stage = op_stage_t'(stage_q);
            op_in.ch    = ch_q;
            op_in.last  = (stage_q == m_q);
        end
    end

    assign RD_EN        = rd_en;
    assign RD_ADDR      = rd_en ? {stage_q, ch_q} : '0;
    assign SRC_IS_INPUT = rd_en && (stage_q == '0);
    assign SRC_ADDR     = (rd_en && stage_q != '0) ? {stage_prev, ch_q} : '0;
    assign WR_EN        = tail.valid;
    assign WR_ADDR      = {STAGE_BITS'(tail.stage), tail.ch};
    assign WR_LAST      = tail.last;
    assign BUSY         = (state_q != S_IDLE);
    assign DONE         = done;
    assign OVERRUN      = ovr_q;

endmodule

// File: tb/tb_theremin_iir_stage_scheduler.sv
// Bench for theremin_iir_stage_scheduler: two instances (latency 2
// and latency 1) driven by shared inputs and a timestamp-based model.
module tb_theremin_iir_stage_scheduler;

    typedef struct packed {
        logic       rd;
        logic [2:0] ra;
        logic [2:0] sa;
        logic       si;
        logic       wr;
        logic [2:0] wa;
        logic       wl;
        logic       busy;
        logic       done;
        logic       ovr;
    } out_t;

    typedef struct packed {
        logic       st;
        logic       rd2;
        logic [2:0] ra2;
        logic       wr2;
        logic       dn2;
        logic       rd1;
        logic [2:0] ra1;
        logic       wr1;
        logic       dn1;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] max_stage;

    logic       rd_en2, src_in2, wr_en2, wr_last2, busy2, done2, ovr2;
    logic [2:0] rd_addr2, src_addr2, wr_addr2;
    logic       rd_en1, src_in1, wr_en1, wr_last1, busy1, done1, ovr1;
    logic [2:0] rd_addr1, src_addr1, wr_addr1;
    out_t       o2, o1, s2, s1;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model state, index 0: latency 2, index 1: latency 1.
    int lat [2] = '{2, 1};
    bit act [2];
    bit pend [2];
    bit ovr [2];
    int mq [2];
    int nops [2];
    int k [2];
    int dn_t [2];
    int iss [2][4][2];

    vec_t tbl [16];
    int   cnt2, cnt1;

    always #5 clk = ~clk;

    theremin_iir_stage_scheduler #(.STAGE_BITS(2), .DP_LATENCY(2)) dut2 (
        .CLK(clk), .RESETN(resetn), .START(start), .MAX_STAGE(max_stage),
        .RD_EN(rd_en2), .RD_ADDR(rd_addr2), .SRC_ADDR(src_addr2),
        .SRC_IS_INPUT(src_in2), .WR_EN(wr_en2), .WR_ADDR(wr_addr2),
        .WR_LAST(wr_last2), .BUSY(busy2), .DONE(done2), .OVERRUN(ovr2)
    );

    theremin_iir_stage_scheduler #(.STAGE_BITS(2), .DP_LATENCY(1)) dut1 (
        .CLK(clk), .RESETN(resetn), .START(start), .MAX_STAGE(max_stage),
        .RD_EN(rd_en1), .RD_ADDR(rd_addr1), .SRC_ADDR(src_addr1),
        .SRC_IS_INPUT(src_in1), .WR_EN(wr_en1), .WR_ADDR(wr_addr1),
        .WR_LAST(wr_last1), .BUSY(busy1), .DONE(done1), .OVERRUN(ovr1)
    );

    assign o2 = {rd_en2, rd_addr2, src_addr2, src_in2, wr_en2, wr_addr2,
                 wr_last2, busy2, done2, ovr2};
    assign o1 = {rd_en1, rd_addr1, src_addr1, src_in1, wr_en1, wr_addr1,
                 wr_last1, busy1, done1, ovr1};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input int st, input int rd2, input int ra2,
                                input int wr2, input int dn2, input int rd1,
                                input int ra1, input int wr1, input int dn1);
        vec_t v;
        v.st  = st[0];
        v.rd2 = rd2[0];
        v.ra2 = 3'(ra2);
        v.wr2 = wr2[0];
        v.dn2 = dn2[0];
        v.rd1 = rd1[0];
        v.ra1 = 3'(ra1);
        v.wr1 = wr1[0];
        v.dn1 = dn1[0];
        return v;
    endfunction

    // Expected outputs this cycle, from issue timestamps of the pass.
    function automatic out_t exp_out(input int i);
        out_t o;
        int   s, c;
        bit   ok;
        o = '0;
        if (act[i]) begin
            o.busy = 1'b1;
            if (k[i] < nops[i]) begin
                s  = k[i] / 2;
                c  = k[i] % 2;
                ok = 1'b1;
                if (s > 0) begin
                    ok = (cyc >= iss[i][s-1][c] + lat[i] + 1);
                end
                if (ok) begin
                    o.rd = 1'b1;
                    o.ra = 3'(k[i]);
                    o.si = (s == 0);
                    o.sa = (s == 0) ? 3'd0 : 3'(k[i] - 2);
                end
            end
            for (int j = 0; j < k[i]; j++) begin
                if (iss[i][j/2][j%2] + lat[i] == cyc) begin
                    o.wr = 1'b1;
                    o.wa = 3'(j);
                    o.wl = ((j / 2) == mq[i]);
                end
            end
            o.done = (cyc == dn_t[i]);
        end
        o.ovr = ovr[i];
        return o;
    endfunction

    task automatic new_pass(input int i, input logic [1:0] ms);
        act[i]  = 1'b1;
        mq[i]   = int'(ms);
        nops[i] = 2 * (int'(ms) + 1);
        k[i]    = 0;
        dn_t[i] = -1;
    endtask

    task automatic upd(input int i, input logic st, input logic [1:0] ms,
                       input logic rn, input out_t e);
        if (!rn) begin
            act[i]  = 1'b0;
            pend[i] = 1'b0;
            ovr[i]  = 1'b0;
        end else begin
            if (e.rd) begin
                iss[i][k[i]/2][k[i]%2] = cyc;
                k[i]++;
                if (k[i] == nops[i]) dn_t[i] = cyc + lat[i] + 1;
            end
            if (!act[i]) begin
                if (st) new_pass(i, ms);
            end else if (cyc == dn_t[i]) begin
                if (pend[i] || st) begin
                    new_pass(i, ms);
                    pend[i] = pend[i] && st;
                end else begin
                    act[i] = 1'b0;
                end
            end else if (st) begin
                if (pend[i]) ovr[i] = 1'b1;
                else pend[i] = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, compare, advance model.
    task automatic cycle(input logic st, input logic [1:0] ms,
                         input logic rn);
        out_t e2, e1;
        start     = st;
        max_stage = ms;
        resetn    = rn;
        @(negedge clk);
        e2 = exp_out(0);
        e1 = exp_out(1);
        s2 = o2;
        s1 = o1;
        chk("model_lat2", 32'(o2), 32'(e2));
        chk("model_lat1", 32'(o1), 32'(e1));
        upd(0, st, ms, rn, e2);
        upd(1, st, ms, rn, e1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        max_stage = 2'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cycle(1'b0, 2'd0, 1'b1);
        chk("reset_outs_l2", 32'(s2), 32'd0);
        chk("reset_outs_l1", 32'(s1), 32'd0);

        // Full pass, MAX_STAGE=3: latency-2 bubbles vs latency-1 stream
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0, 1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 1, 2, 1, 0);
        tbl[4]  = mk(0, 1, 2, 1, 0, 1, 3, 1, 0);
        tbl[5]  = mk(0, 1, 3, 0, 0, 1, 4, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0, 1, 5, 1, 0);
        tbl[7]  = mk(0, 1, 4, 1, 0, 1, 6, 1, 0);
        tbl[8]  = mk(0, 1, 5, 0, 0, 1, 7, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 6, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 7, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 16; t++) begin
            cycle(tbl[t].st, 2'd3, 1'b1);
            chk($sformatf("table_t%0d", t),
                32'({s2.rd, s2.ra, s2.wr, s2.done,
                     s1.rd, s1.ra, s1.wr, s1.done}),
                32'({tbl[t].rd2, tbl[t].ra2, tbl[t].wr2, tbl[t].dn2,
                     tbl[t].rd1, tbl[t].ra1, tbl[t].wr1, tbl[t].dn1}));
        end

        // START while busy queues one pass; a second one overruns
        cycle(1'b1, 2'd1, 1'b1);
        repeat (4) cycle(1'b0, 2'd1, 1'b1);
        cycle(1'b1, 2'd1, 1'b1);
        cycle(1'b1, 2'd1, 1'b1);
        cycle(1'b0, 2'd1, 1'b1);
        chk("overrun_set", 32'(s2.ovr), 32'd1);
        cycle(1'b0, 2'd1, 1'b1);
        chk("done_no_rd", 32'({s2.done, s2.rd}), 32'(2'b10));
        cycle(1'b0, 2'd1, 1'b1);
        chk("pending_pass_rd", 32'({s2.rd, s2.ra}), 32'({1'b1, 3'd0}));
        repeat (20) cycle(1'b0, 2'd1, 1'b1);

        // Reset mid-pass kills in-flight writes
        cycle(1'b1, 2'd3, 1'b1);
        cycle(1'b0, 2'd3, 1'b1);
        cycle(1'b0, 2'd3, 1'b1);
        cycle(1'b0, 2'd3, 1'b0);
        for (int t = 0; t < 12; t++) begin
            cycle(1'b0, 2'd3, 1'b1);
            chk("post_reset_l2", 32'(s2), 32'd0);
            chk("post_reset_l1", 32'(s1), 32'd0);
        end
        cycle(1'b1, 2'd3, 1'b1);
        cycle(1'b0, 2'd3, 1'b1);
        chk("clean_restart", 32'({s2.rd, s2.ra, s2.si}),
            32'({1'b1, 3'd0, 1'b1}));
        repeat (16) cycle(1'b0, 2'd3, 1'b1);

        // Single stage: both writes are final
        cycle(1'b1, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        chk("one_stage_wr0_l1", 32'({s1.wr, s1.wa, s1.wl}),
            32'({1'b1, 3'd0, 1'b1}));
        cycle(1'b0, 2'd0, 1'b1);
        chk("one_stage_wr0_l2", 32'({s2.wr, s2.wa, s2.wl}),
            32'({1'b1, 3'd0, 1'b1}));
        chk("one_stage_wr1_l1", 32'({s1.wr, s1.wa, s1.wl}),
            32'({1'b1, 3'd1, 1'b1}));
        cycle(1'b0, 2'd0, 1'b1);
        chk("one_stage_wr1_l2", 32'({s2.wr, s2.wa, s2.wl}),
            32'({1'b1, 3'd1, 1'b1}));
        repeat (6) cycle(1'b0, 2'd0, 1'b1);

        // MAX_STAGE change mid-pass only affects the next pass
        cnt2 = 0;
        cnt1 = 0;
        cycle(1'b1, 2'd3, 1'b1);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b0, (t < 2) ? 2'd3 : 2'd1, 1'b1);
            cnt2 += int'(s2.rd);
            cnt1 += int'(s1.rd);
        end
        chk("mid_change_ops_l2", 32'(cnt2), 32'd8);
        chk("mid_change_ops_l1", 32'(cnt1), 32'd8);
        cnt2 = 0;
        cnt1 = 0;
        cycle(1'b1, 2'd1, 1'b1);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b0, 2'd1, 1'b1);
            cnt2 += int'(s2.rd);
            cnt1 += int'(s1.rd);
        end
        chk("next_pass_ops_l2", 32'(cnt2), 32'd4);
        chk("next_pass_ops_l1", 32'(cnt1), 32'd4);

        // Random traffic against the model
        for (int t = 0; t < 1500; t++) begin
            cycle(($urandom_range(0, 6) == 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 149) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
